// File: rtl/accel_cmd_driver.sv
// Initiator for the start/done/rst2 accelerator handshake: accepts operand pairs,
// launches the accelerator, captures its result. Optional macro: DRIVER_TIMEOUT_EN.
module accel_cmd_driver #(
  parameter int WIDTH   = 16,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err,
  output logic             acc_start,
  output logic             acc_rst2,
  output logic [WIDTH-1:0] acc_in1,
  output logic [WIDTH-1:0] acc_in2,
  input  logic             acc_done,
  input  logic [WIDTH-1:0] acc_result,
  output logic [CNT_W-1:0] txn_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RELEASE
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_acc_start;
  logic             r_acc_rst2;
  logic [WIDTH-1:0] r_acc_in1;
  logic [WIDTH-1:0] r_acc_in2;
  logic             r_resp_valid;
  logic [WIDTH-1:0] r_resp_data;
  logic [CNT_W-1:0] r_txn_count;
  logic             w_accept;
  logic             w_complete;
  logic             w_timeout;

  assign req_ready  = (r_state == S_IDLE) && !r_resp_valid;
  assign w_accept   = req_valid && req_ready;
  assign w_complete = (r_state == S_WAIT) && acc_done;

`ifdef DRIVER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] r_wait_cnt;
  logic            r_resp_err;

  // acc_done has priority: a timeout only fires when done is still low.
  assign w_timeout = (r_state == S_WAIT) && !acc_done &&
                     (r_wait_cnt == TO_W'(TIMEOUT - 1));
  assign resp_err  = r_resp_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_resp_err <= 1'b0;
    end else begin
      if (r_state == S_LAUNCH) begin
        r_wait_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_complete) begin
        r_resp_err <= 1'b0;
      end else if (w_timeout) begin
        r_resp_err <= 1'b1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign resp_err  = 1'b0;
`endif

  // NOTE: every signal assigned here gets its default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:    if (w_accept) w_next_state = S_LAUNCH;
      S_LAUNCH:  w_next_state = S_WAIT;
      S_WAIT:    if (w_complete || w_timeout) w_next_state = S_RELEASE;
      S_RELEASE: w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep every flop reading pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_acc_start  <= 1'b0;
      r_acc_rst2   <= 1'b0;
      r_acc_in1    <= '0;
      r_acc_in2    <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_txn_count  <= '0;
    end else begin
      r_state     <= w_next_state;
      // Strobes are decoded from the next state so they are flop outputs, glitch-free.
      r_acc_start <= (w_next_state == S_LAUNCH);
      r_acc_rst2  <= (w_next_state == S_RELEASE);

      if (w_accept) begin
        r_acc_in1 <= req_a;
        r_acc_in2 <= req_b;
      end

      if (w_complete) begin
        r_resp_data  <= acc_result;
        r_resp_valid <= 1'b1;
        r_txn_count  <= r_txn_count + 1'b1;
      end else if (w_timeout) begin
        r_resp_data  <= '0;
        r_resp_valid <= 1'b1;
      end else if (r_resp_valid && resp_ready) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  assign acc_start  = r_acc_start;
  assign acc_rst2   = r_acc_rst2;
  assign acc_in1    = r_acc_in1;
  assign acc_in2    = r_acc_in2;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign txn_count  = r_txn_count;

endmodule
